// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store initiator: access-size codes, FSM states
// and the alignment rule used to reject requests before any memory access.
`timescale 1ns/1ps
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAPT,
        ST_WR,
        ST_RESP
    } state_t;

    // Illegal size counts as misaligned so a single check gates the error path.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return (offset != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane steering: extracts/extends a little-endian load lane and
// merges right-aligned store data into the addressed lane of a read word.
`timescale 1ns/1ps
module mau_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word_i[7:0];
        case (offset_i)
            2'd1:    byte_lane = word_i[15:8];
            2'd2:    byte_lane = word_i[23:16];
            2'd3:    byte_lane = word_i[31:24];
            default: byte_lane = word_i[7:0];
        endcase
        half_lane = offset_i[1] ? word_i[31:16] : word_i[15:0];

        case (size_i)
            SZ_BYTE: load_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_o = {{16{signed_i & half_lane[15]}}, half_lane};
            default: load_o = word_i;
        endcase

        merged_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                case (offset_i)
                    2'd1:    merged_o[15:8]  = wdata_i[7:0];
                    2'd2:    merged_o[23:16] = wdata_i[7:0];
                    2'd3:    merged_o[31:24] = wdata_i[7:0];
                    default: merged_o[7:0]   = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset_i[1]) merged_o[31:16] = wdata_i[15:0];
                else             merged_o[15:0]  = wdata_i[15:0];
            end
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: valid/ready request in, one-cycle response pulse out,
// absorbing the memory's registered read and doing read-modify-write for sub-word stores.
//
// state   | meaning
// IDLE    | req_ready high, latch request on req_valid
// RD      | word address presented to memory, read in flight
// CAPT    | read data valid: extract load lane or build merged store word
// WR      | mem_write high for one cycle with full or merged word
// RESP    | resp_valid pulse, result already registered
`timescale 1ns/1ps
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [17:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_datain,
    input  logic [31:0] mem_dataout
);

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_datain_q, mem_datain_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] load_val;
    logic [31:0] merged_word;

    mau_lane_align u_align (
        .word_i   (mem_dataout),
        .offset_i (offset_q),
        .size_i   (size_q),
        .signed_i (signed_q),
        .wdata_i  (wdata_q),
        .load_o   (load_val),
        .merged_o (merged_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            offset_q     <= 2'b00;
            wdata_q      <= 32'h0;
            mem_addr_q   <= 16'h0;
            mem_datain_q <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            offset_q     <= offset_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_datain_q <= mem_datain_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        offset_d     = offset_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_datain_d = mem_datain_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    offset_d = req_addr[1:0];
                    wdata_d  = req_wdata;
                    if (misaligned(req_size, req_addr[1:0])) begin
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                        state_d      = ST_RESP;
                    end else if (req_write && req_size == SZ_WORD) begin
                        // Full-word store skips the read; address and data go out at acceptance.
                        mem_addr_d   = req_addr[17:2];
                        mem_datain_d = req_wdata;
                        state_d      = ST_WR;
                    end else begin
                        mem_addr_d = req_addr[17:2];
                        state_d    = ST_RD;
                    end
                end
            end
            ST_RD: state_d = ST_CAPT;
            ST_CAPT: begin
                if (write_q) begin
                    mem_datain_d = merged_word;
                    state_d      = ST_WR;
                end else begin
                    resp_rdata_d = load_val;
                    resp_err_d   = 1'b0;
                    state_d      = ST_RESP;
                end
            end
            ST_WR: begin
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
                state_d      = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign mem_write  = (state_q == ST_WR);
    assign resp_valid = (state_q == ST_RESP);
    assign mem_addr   = mem_addr_q;
    assign mem_datain = mem_datain_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit against a registered-read word memory: directed table,
// back-to-back and mid-operation reset sequences, then random requests vs a reference model.
`timescale 1ns/1ps
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout;

    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_datain  (mem_datain),
        .mem_dataout (mem_dataout)
    );

    // Data memory: registered read returns the pre-write value on a same-cycle write.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_datain;
        mem_dataout <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: behaviour from the access rules using masks and shifts on a word array.
    function automatic void ref_model(input logic w, input logic [1:0] sz, input logic sg,
                                      input logic [17:0] a, input logic [31:0] wd,
                                      output logic [31:0] rd, output logic err, output int lat);
        int          nb, sh;
        logic [31:0] mask, old, v;
        logic [15:0] idx;
        idx  = a[17:2];
        sh   = 8 * int'(a[1:0]);
        nb   = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
        mask = (nb == 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
        old  = ref_mem[idx];
        err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        rd   = 32'h0;
        if (err) begin
            lat = 1;
        end else if (w) begin
            ref_mem[idx] = (old & ~(mask << sh)) | ((wd & mask) << sh);
            lat = (sz == 2'd2) ? 2 : 4;
        end else begin
            v = (old >> sh) & mask;
            if (sg && nb < 32 && v[nb-1]) v = v | ~mask;
            rd  = v;
            lat = 3;
        end
    endfunction

    task automatic apply(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [17:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int          lat, wr_cnt, wr_cyc;
        logic [31:0] rd;
        logic        er, addr_held;
        logic [15:0] wr_addr, addr_before;
        lat = -1; wr_cnt = 0; wr_cyc = -1; addr_held = 1'b1;
        rd = 32'h0; er = 1'b0; wr_addr = 16'h0;
        @(negedge clk);
        addr_before = mem_addr;
        chk({nm, " ready"}, {31'h0, req_ready}, 32'h1);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = 18'($urandom);
        req_wdata  = $urandom;
        for (int n = 1; n <= 8 && lat < 0; n++) begin
            @(negedge clk);
            if (mem_write) begin
                wr_cnt++;
                wr_cyc  = n;
                wr_addr = mem_addr;
            end
            if (mem_addr != addr_before) addr_held = 1'b0;
            if (resp_valid) begin
                lat = n;
                rd  = resp_rdata;
                er  = resp_err;
            end
        end
        chk({nm, " latency"}, lat, exp_lat);
        chk({nm, " rdata"}, rd, exp_rd);
        chk({nm, " err"}, {31'h0, er}, {31'h0, exp_err});
        chk({nm, " write count"}, wr_cnt, (w && !exp_err) ? 1 : 0);
        if (wr_cnt > 0) begin
            chk({nm, " write cycle"}, wr_cyc, exp_lat - 1);
            chk({nm, " write addr"}, {16'h0, wr_addr}, {16'h0, a[17:2]});
        end
        if (exp_err) chk({nm, " addr held"}, {31'h0, addr_held}, 32'h1);
        @(negedge clk);
        chk({nm, " single pulse"}, {31'h0, resp_valid}, 32'h0);
        chk({nm, " memory word"}, mem[a[17:2]], ref_mem[a[17:2]]);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [17:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vt[15];

    initial begin
        logic [31:0] m_rd;
        logic        m_err;
        int          m_lat;
        int          acc_cyc, pulses, first_p, second_p;
        logic [31:0] last_rd, word_before;
        logic [17:0] ra;

        vt[0]  = '{1'b1, 2'd2, 1'b0, 18'h00010, 32'hDEADBEEF, 32'h00000000, 1'b0, 2};
        vt[1]  = '{1'b0, 2'd2, 1'b0, 18'h00010, 32'h0,        32'hDEADBEEF, 1'b0, 3};
        vt[2]  = '{1'b1, 2'd0, 1'b0, 18'h00011, 32'h000000AB, 32'h00000000, 1'b0, 4};
        vt[3]  = '{1'b0, 2'd0, 1'b1, 18'h00013, 32'h0,        32'hFFFFFFDE, 1'b0, 3};
        vt[4]  = '{1'b0, 2'd0, 1'b0, 18'h00013, 32'h0,        32'h000000DE, 1'b0, 3};
        vt[5]  = '{1'b0, 2'd2, 1'b0, 18'h00010, 32'h0,        32'hDEADABEF, 1'b0, 3};
        vt[6]  = '{1'b1, 2'd1, 1'b0, 18'h00012, 32'h00001234, 32'h00000000, 1'b0, 4};
        vt[7]  = '{1'b0, 2'd1, 1'b1, 18'h00010, 32'h0,        32'hFFFFABEF, 1'b0, 3};
        vt[8]  = '{1'b0, 2'd1, 1'b0, 18'h00012, 32'h0,        32'h00001234, 1'b0, 3};
        vt[9]  = '{1'b0, 2'd2, 1'b0, 18'h00011, 32'h0,        32'h00000000, 1'b1, 1};
        vt[10] = '{1'b1, 2'd1, 1'b0, 18'h00013, 32'h5555AAAA, 32'h00000000, 1'b1, 1};
        vt[11] = '{1'b0, 2'd3, 1'b0, 18'h00010, 32'h0,        32'h00000000, 1'b1, 1};
        vt[12] = '{1'b0, 2'd2, 1'b0, 18'h00010, 32'h0,        32'h1234ABEF, 1'b0, 3};
        vt[13] = '{1'b1, 2'd0, 1'b0, 18'h00010, 32'hFFFFFF5A, 32'h00000000, 1'b0, 4};
        vt[14] = '{1'b0, 2'd2, 1'b1, 18'h00010, 32'h0,        32'h1234AB5A, 1'b0, 3};

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 18'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset req_ready",  {31'h0, req_ready},  32'h1);
        chk("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("reset mem_write",  {31'h0, mem_write},  32'h0);
        chk("reset mem_addr",   {16'h0, mem_addr},   32'h0);
        chk("reset mem_datain", mem_datain,          32'h0);
        chk("reset resp_rdata", resp_rdata,          32'h0);
        chk("reset resp_err",   {31'h0, resp_err},   32'h0);
        reset = 1'b0;

        foreach (vt[i]) begin
            ref_model(vt[i].w, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, m_rd, m_err, m_lat);
            apply($sformatf("vec%0d", i), vt[i].w, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd,
                  vt[i].rd, vt[i].err, vt[i].lat);
        end

        // req_valid held across a word store and a following load
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 18'h00020;
        req_wdata = 32'h11111111; req_valid = 1'b1;
        ref_model(1'b1, 2'd2, 1'b0, 18'h00020, 32'h11111111, m_rd, m_err, m_lat);
        @(posedge clk);
        #1;
        req_write = 1'b0; req_size = 2'd2; req_addr = 18'h00020; req_wdata = 32'h0;
        acc_cyc = -1; pulses = 0; first_p = -1; second_p = -1; last_rd = 32'h0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                pulses++;
                if (first_p < 0) first_p = n; else second_p = n;
                last_rd = resp_rdata;
            end
            if (req_ready && req_valid && acc_cyc < 0) begin
                acc_cyc = n;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        chk("b2b accept edge", acc_cyc, 3);
        chk("b2b pulses", pulses, 2);
        chk("b2b first resp cycle", first_p, 2);
        chk("b2b second resp cycle", second_p, 6);
        chk("b2b load data", last_rd, 32'h11111111);

        // reset during CAPT of a byte store at 0x11
        word_before = mem[16'h0004];
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 18'h00011;
        req_wdata = 32'h000000C3; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst mid mem_write",  {31'h0, mem_write},  32'h0);
        chk("rst mid resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst mid mem_addr",   {16'h0, mem_addr},   32'h0);
        chk("rst mid mem_datain", mem_datain,          32'h0);
        chk("rst mid resp_rdata", resp_rdata,          32'h0);
        chk("rst mid resp_err",   {31'h0, resp_err},   32'h0);
        reset = 1'b0;
        pulses = 0; acc_cyc = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
            if (mem_write)  acc_cyc++;
        end
        chk("rst after resp count",  pulses, 0);
        chk("rst after write count", acc_cyc, 0);
        chk("rst word unchanged", mem[16'h0004], word_before);
        chk("rst req_ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 300; i++) begin
            logic        w, sg;
            logic [1:0]  sz;
            logic [31:0] wd;
            w  = 1'($urandom);
            sg = 1'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ra = ($urandom_range(0, 15) == 0) ? {16'hFFFF, 2'($urandom)}
                                              : {16'($urandom_range(0, 7)), 2'($urandom)};
            wd = $urandom;
            ref_model(w, sz, sg, ra, wd, m_rd, m_err, m_lat);
            apply($sformatf("rnd%0d", i), w, sz, sg, ra, wd, m_rd, m_err, m_lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
